// File: rtl/svm_decision_acc.sv
// SVM decision accumulator: weights one kernel value per support vector by its
// signed coefficient, sums with saturation, adds the bias and reports the class.
module svm_decision_acc #(
  parameter int XLEN_PIXEL = 8,
  parameter int NUM_OF_SV  = 10,
  parameter int ACC_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      kernel_valid,
  output logic                      kernel_ready,
  input  logic [2*XLEN_PIXEL-1:0]   kernel_in,
  input  logic [2*XLEN_PIXEL-1:0]   coef_in,
  input  logic [2*XLEN_PIXEL-1:0]   bias,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [ACC_W-1:0]          dec_value,
  output logic                      dec_class,
  output logic                      sat,
  output logic                      busy
);

  localparam int DW    = 2 * XLEN_PIXEL;
  localparam int PW    = 2 * DW + 1;
  localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 2;
  localparam int CNT_W = $clog2(NUM_OF_SV + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] BIAS  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OF_SV - 1);

  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]              state_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    sat_acc_reg;
  logic                    kernel_ready_reg;
  logic                    dec_valid_reg;
  logic signed [ACC_W-1:0] dec_value_reg;
  logic                    dec_class_reg;
  logic                    sat_reg;

  logic signed [PW-1:0]    kern_ext;
  logic signed [PW-1:0]    coef_ext;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    term;
  logic signed [SUM_W-1:0] addend;
  logic signed [SUM_W-1:0] sum_wide;
  logic signed [ACC_W-1:0] sum_next;
  logic                    clamp_next;
  logic                    accept;

  // Kernel is unsigned, so it gets a zero MSB before the signed multiply.
  assign kern_ext = {{(PW-DW){1'b0}}, kernel_in};
  assign coef_ext = {{(PW-DW){coef_in[DW-1]}}, coef_in};
  assign prod     = kern_ext * coef_ext;
  assign term     = prod >>> XLEN_PIXEL;

  assign accept = (state_reg == ACCUM) && kernel_valid && kernel_ready_reg;

  // One shared saturating adder: the kernel term in ACCUM, the bias in BIAS.
  always_comb begin
    addend = {{(SUM_W-PW){term[PW-1]}}, term};
    if (state_reg == BIAS) begin
      addend = {{(SUM_W-DW){bias[DW-1]}}, bias};
    end
    sum_wide   = {{(SUM_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg} + addend;
    sum_next   = sum_wide[ACC_W-1:0];
    clamp_next = 1'b0;
    if (sum_wide > SUM_MAX) begin
      sum_next   = ACC_MAX;
      clamp_next = 1'b1;
    end else if (sum_wide < SUM_MIN) begin
      sum_next   = ACC_MIN;
      clamp_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      acc_reg          <= '0;
      cnt_reg          <= '0;
      sat_acc_reg      <= 1'b0;
      kernel_ready_reg <= 1'b0;
      dec_valid_reg    <= 1'b0;
      dec_value_reg    <= '0;
      dec_class_reg    <= 1'b0;
      sat_reg          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg          <= '0;
            cnt_reg          <= '0;
            sat_acc_reg      <= 1'b0;
            sat_reg          <= 1'b0;
            dec_value_reg    <= '0;
            dec_class_reg    <= 1'b0;
            kernel_ready_reg <= 1'b1;
            state_reg        <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_reg     <= sum_next;
            sat_acc_reg <= sat_acc_reg | clamp_next;
            cnt_reg     <= cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_CNT) begin
              kernel_ready_reg <= 1'b0;
              state_reg        <= BIAS;
            end
          end
        end
        BIAS: begin
          // Outputs are published here so they appear together with DONE.
          acc_reg       <= sum_next;
          sat_acc_reg   <= sat_acc_reg | clamp_next;
          dec_valid_reg <= 1'b1;
          dec_value_reg <= sum_next;
          dec_class_reg <= ~sum_next[ACC_W-1];
          sat_reg       <= sat_acc_reg | clamp_next;
          state_reg     <= DONE;
        end
        DONE: begin
          if (dec_ready) begin
            dec_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign kernel_ready = kernel_ready_reg;
  assign dec_valid    = dec_valid_reg;
  assign dec_value    = dec_value_reg;
  assign dec_class    = dec_class_reg;
  assign sat          = sat_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_svm_decision_acc.sv
// Directed bench for svm_decision_acc: a 32-bit accumulator instance for the
// arithmetic/handshake cases and a 20-bit instance for saturation.
module tb_svm_decision_acc;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kernel_valid;
  logic [15:0] kernel_in;
  logic [15:0] coef_in;
  logic [15:0] bias;
  logic        dec_ready;

  logic        kernel_ready, dec_valid, dec_class, sat, busy;
  logic [31:0] dec_value;
  logic        kernel_ready_s, dec_valid_s, dec_class_s, sat_s, busy_s;
  logic [19:0] dec_value_s;

  int checks = 0;
  int errors = 0;

  svm_decision_acc #(.XLEN_PIXEL(8), .NUM_OF_SV(10), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kernel_valid(kernel_valid),
    .kernel_ready(kernel_ready), .kernel_in(kernel_in), .coef_in(coef_in),
    .bias(bias), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_value(dec_value), .dec_class(dec_class), .sat(sat), .busy(busy)
  );

  svm_decision_acc #(.XLEN_PIXEL(8), .NUM_OF_SV(10), .ACC_W(20)) dut_s (
    .clk(clk), .rst(rst), .start(start), .kernel_valid(kernel_valid),
    .kernel_ready(kernel_ready_s), .kernel_in(kernel_in), .coef_in(coef_in),
    .bias(bias), .dec_valid(dec_valid_s), .dec_ready(dec_ready),
    .dec_value(dec_value_s), .dec_class(dec_class_s), .sat(sat_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a decision and feeds terms until stop_after accepts (or a cycle budget
  // runs out). kernel_valid is high every (gap+1)th cycle; idle cycles carry the
  // sentinel kernel value. Returns observations around the last accept.
  task automatic run_decision(input logic [15:0] k, input logic [15:0] c, input logic [15:0] b,
                              input int gap, input int start_at, input int stop_after,
                              output int accepts, output logic kr_after,
                              output logic dv_bias, output logic dv_done);
    int   cyc;
    logic kr;
    logic pulsed;
    bias = b; coef_in = c; kernel_in = 16'hFFFF; kernel_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    accepts = 0; cyc = 0; pulsed = 1'b0;
    while (accepts < stop_after && cyc < 200) begin
      kernel_valid = ((cyc % (gap + 1)) == 0);
      kernel_in    = kernel_valid ? k : 16'hFFFF;
      if (start_at >= 0 && !pulsed && accepts == start_at) begin
        start = 1'b1; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      kr = kernel_ready;
      @(posedge clk); #1;
      if (kernel_valid && kr) accepts++;
      cyc++;
    end
    start = 1'b0; kernel_valid = 1'b0; kernel_in = 16'hFFFF;
    kr_after = kernel_ready;
    dv_bias  = dec_valid;
    dv_done  = 1'b0;
    if (stop_after >= 10) begin
      @(posedge clk); #1;
      dv_done = dec_valid;
    end
    $display("decision k=%h c=%h b=%h accepts=%0d value=%h class=%0b sat=%0b",
             k, c, b, accepts, dec_value, dec_class, sat);
  endtask

  task automatic handshake();
    dec_ready = 1'b1;
    @(posedge clk); #1;
    dec_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; kernel_valid = 1'b0; kernel_in = 16'hFFFF;
    coef_in = '0; bias = '0; dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (kernel_ready !== 1'b0) begin errors++; $display("FAIL reset_kr: got %b expected 0", kernel_ready); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", dec_valid); end
    checks++; if (dec_value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h expected 0", dec_value); end
    checks++; if (dec_class !== 1'b0) begin errors++; $display("FAIL reset_class: got %b expected 0", dec_class); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_positive();
    int acc_n; logic kra, dvb, dvd;
    run_decision(16'h0100, 16'h0080, 16'hFF00, 0, -1, 10, acc_n, kra, dvb, dvd);
    checks++; if (acc_n !== 10) begin errors++; $display("FAIL pos_accepts: got %0d expected 10", acc_n); end
    checks++; if (kra !== 1'b0) begin errors++; $display("FAIL pos_kr_drop: got %b expected 0", kra); end
    checks++; if (dvb !== 1'b0) begin errors++; $display("FAIL pos_dv_early: got %b expected 0", dvb); end
    checks++; if (dvd !== 1'b1) begin errors++; $display("FAIL pos_dv_latency: got %b expected 1", dvd); end
    checks++; if (dec_value !== 32'h0000_0400) begin errors++; $display("FAIL pos_value: got %h expected 00000400", dec_value); end
    checks++; if (dec_class !== 1'b1) begin errors++; $display("FAIL pos_class: got %b expected 1", dec_class); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL pos_sat: got %b expected 0", sat); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pos_busy: got %b expected 1", busy); end
    handshake();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL pos_dv_clear: got %b expected 0", dec_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pos_idle: got %b expected 0", busy); end
  endtask

  task automatic test_negative();
    int acc_n; logic kra, dvb, dvd;
    run_decision(16'h0100, 16'hFF80, 16'h0000, 0, -1, 10, acc_n, kra, dvb, dvd);
    checks++; if (dec_value !== 32'hFFFF_FB00) begin errors++; $display("FAIL neg_value: got %h expected FFFFFB00", dec_value); end
    checks++; if (dec_class !== 1'b0) begin errors++; $display("FAIL neg_class: got %b expected 0", dec_class); end
    handshake();
    // Ten +0.5 terms cancelled exactly by a -5.0 bias.
    run_decision(16'h0100, 16'h0080, 16'hFB00, 0, -1, 10, acc_n, kra, dvb, dvd);
    checks++; if (dec_value !== 32'h0) begin errors++; $display("FAIL zero_value: got %h expected 00000000", dec_value); end
    checks++; if (dec_class !== 1'b1) begin errors++; $display("FAIL zero_class: got %b expected 1", dec_class); end
    handshake();
  endtask

  task automatic test_rounding();
    int acc_n; logic kra, dvb, dvd;
    // 1 * -1 = -1 raw; the shift floors to -1 LSB per term, not to zero.
    run_decision(16'h0001, 16'hFFFF, 16'h0000, 0, -1, 10, acc_n, kra, dvb, dvd);
    checks++; if (dec_value !== 32'hFFFF_FFF6) begin errors++; $display("FAIL floor_value: got %h expected FFFFFFF6", dec_value); end
    handshake();
  endtask

  task automatic test_backpressure();
    int acc_n; logic kra, dvb, dvd;
    run_decision(16'h0100, 16'h0080, 16'hFF00, 2, -1, 10, acc_n, kra, dvb, dvd);
    checks++; if (acc_n !== 10) begin errors++; $display("FAIL bp_accepts: got %0d expected 10", acc_n); end
    checks++; if (dvd !== 1'b1) begin errors++; $display("FAIL bp_dv_latency: got %b expected 1", dvd); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_dv[%0d]: got %b expected 1", i, dec_valid); end
      checks++; if (dec_value !== 32'h0000_0400) begin errors++; $display("FAIL bp_hold_value[%0d]: got %h expected 00000400", i, dec_value); end
    end
    handshake();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL bp_dv_clear: got %b expected 0", dec_valid); end
  endtask

  task automatic test_saturation();
    int acc_n; logic kra, dvb, dvd;
    run_decision(16'hFFFF, 16'h7FFF, 16'h0000, 0, -1, 10, acc_n, kra, dvb, dvd);
    checks++; if (dec_valid_s !== 1'b1) begin errors++; $display("FAIL sat_dv: got %b expected 1", dec_valid_s); end
    checks++; if (dec_value_s !== 20'h7FFFF) begin errors++; $display("FAIL sat_value: got %h expected 7FFFF", dec_value_s); end
    checks++; if (sat_s !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b expected 1", sat_s); end
    checks++; if (dec_class_s !== 1'b1) begin errors++; $display("FAIL sat_class: got %b expected 1", dec_class_s); end
    checks++; if (kernel_ready_s !== 1'b0 || busy_s !== 1'b1) begin errors++; $display("FAIL sat_state: got kr=%b busy=%b expected kr=0 busy=1", kernel_ready_s, busy_s); end
    // The wide instance holds 10 * 8388224 without clamping.
    checks++; if (dec_value !== 32'h04FF_F100 || sat !== 1'b0) begin errors++; $display("FAIL wide_value: got %h sat=%b expected 04FFF100 sat=0", dec_value, sat); end
    handshake();
    checks++; if (sat_s !== 1'b1) begin errors++; $display("FAIL sat_sticky_idle: got %b expected 1", sat_s); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (sat_s !== 1'b0) begin errors++; $display("FAIL sat_clear_on_start: got %b expected 0", sat_s); end
    run_decision(16'h0100, 16'h0080, 16'hFF00, 0, -1, 10, acc_n, kra, dvb, dvd);
    checks++; if (dec_value_s !== 20'h00400 || sat_s !== 1'b0) begin errors++; $display("FAIL sat_next_value: got %h sat=%b expected 00400 sat=0", dec_value_s, sat_s); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int acc_n; logic kra, dvb, dvd;
    run_decision(16'h0100, 16'h0080, 16'hFF00, 0, -1, 4, acc_n, kra, dvb, dvd);
    checks++; if (acc_n !== 4 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got accepts=%0d busy=%b expected 4 busy=1", acc_n, busy); end
    rst = 1'b0;
    #2;
    checks++; if (kernel_ready !== 1'b0) begin errors++; $display("FAIL mid_kr: got %b expected 0", kernel_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (dec_valid !== 1'b0 || dec_value !== 32'h0 || dec_class !== 1'b0 || sat !== 1'b0) begin
      errors++; $display("FAIL mid_outputs: got dv=%b value=%h class=%b sat=%b expected all 0", dec_valid, dec_value, dec_class, sat);
    end
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    run_decision(16'h0100, 16'h0080, 16'hFF00, 0, -1, 10, acc_n, kra, dvb, dvd);
    checks++; if (dvd !== 1'b1 || dec_value !== 32'h0000_0400) begin errors++; $display("FAIL mid_fresh: got dv=%b value=%h expected dv=1 value=00000400", dvd, dec_value); end
    handshake();
  endtask

  task automatic test_start_ignored();
    int acc_n; logic kra, dvb, dvd;
    run_decision(16'h0100, 16'h0080, 16'hFF00, 0, 3, 10, acc_n, kra, dvb, dvd);
    checks++; if (acc_n !== 10 || dvd !== 1'b1) begin errors++; $display("FAIL ign_accum: got accepts=%0d dv=%b expected 10 dv=1", acc_n, dvd); end
    checks++; if (dec_value !== 32'h0000_0400) begin errors++; $display("FAIL ign_value: got %h expected 00000400", dec_value); end
    start = 1'b1;
    @(posedge clk); #1;
    checks++; if (dec_valid !== 1'b1 || dec_value !== 32'h0000_0400) begin errors++; $display("FAIL ign_done: got dv=%b value=%h expected dv=1 value=00000400", dec_valid, dec_value); end
    dec_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dec_ready = 1'b0;
    checks++; if (dec_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ign_handshake: got dv=%b busy=%b expected 0 0", dec_valid, busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || kernel_ready !== 1'b0) begin errors++; $display("FAIL ign_no_extra: got busy=%b kr=%b expected 0 0", busy, kernel_ready); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_rounding();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
